// File: rtl/unidade_busca_pkg.sv
// Shared constants and types for the instruction fetch unit.
// The entry typedef uses the default address width.
package unidade_busca_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } fetch_entry_t;

endpackage

// File: rtl/unidade_busca_fila_prefetch.sv
// Parametric synchronous FIFO holding fetched {pc, instr} words.
// Provides a synchronous clear that wins over push and pop.
module fila_prefetch #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Storage is never reset; empty-state masking is done by the consumer.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_comb begin
    head  = mem[rd_ptr];
    empty = (count == '0);
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: owns the PC, issues reads to a synchronous
// instruction memory and buffers returned words in a prefetch FIFO.
module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] iin,
  output logic [ADDR_W-1:0]  iin_pc,
  output logic               iin_valid,
  input  logic               iin_ready,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned ENT_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic              fifo_empty;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  entry_t            push_entry;
  entry_t            head_entry;

  // Occupancy counts the in-flight word so the FIFO can never overflow.
  always_comb begin
    occupancy  = {1'b0, count} + (CNT_W+1)'(inflight);
    issue      = !reset && !jump && !halt && (occupancy < DEPTH_L);
    push       = inflight && !jump;
    pop        = !fifo_empty && iin_ready && !jump;
    push_entry = '{pc: inflight_pc, instr: mem_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (jump) begin
      fetch_pc <= jump_addr;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(1);
      end
    end
  end

  fila_prefetch #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fila (
    .clk   (clock),
    .rst   (reset),
    .clear (jump),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head_entry),
    .count (count),
    .empty (fifo_empty)
  );

  always_comb begin
    mem_addr  = fetch_pc;
    mem_rd    = issue;
    iin_valid = !fifo_empty;
    iin       = fifo_empty ? '0 : head_entry.instr;
    iin_pc    = fifo_empty ? '0 : head_entry.pc;
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca with a synchronous memory model
// returning 0x1000 + address one cycle after each read.
module tb_unidade_busca;

  logic        clock;
  logic        reset;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic [15:0] iin;
  logic [7:0]  iin_pc;
  logic        iin_valid;
  logic        iin_ready;
  logic        jump;
  logic [7:0]  jump_addr;
  logic        halt;

  int n_tests = 0;
  int n_fail  = 0;
  int reads;

  unidade_busca #(.ADDR_W(8), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .iin       (iin),
    .iin_pc    (iin_pc),
    .iin_valid (iin_valid),
    .iin_ready (iin_ready),
    .jump      (jump),
    .jump_addr (jump_addr),
    .halt      (halt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd) mem_data <= 16'h1000 + {8'h00, mem_addr};
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; jump = 1'b0; jump_addr = 8'h00; halt = 1'b0; iin_ready = 1'b1;
    repeat (2) tick;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_valid", iin_valid, 0);
    chk("rst_iin", iin, 0);
    chk("rst_iin_pc", iin_pc, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // streaming: cycle 0 after release
    reset = 1'b0; #1;
    chk("c0_mem_rd", mem_rd, 1);
    chk("c0_mem_addr", mem_addr, 0);
    chk("c0_valid", iin_valid, 0);
    tick;
    chk("c1_mem_rd", mem_rd, 1);
    chk("c1_mem_addr", mem_addr, 1);
    chk("c1_valid", iin_valid, 0);
    for (int c = 2; c <= 5; c++) begin
      tick;
      chk("stream_valid", iin_valid, 1);
      chk("stream_iin", iin, 32'h1000 + c - 2);
      chk("stream_pc", iin_pc, c - 2);
      chk("stream_mem_addr", mem_addr, c);
    end

    // backpressure from a fresh start
    reset = 1'b1; iin_ready = 1'b0;
    tick; tick;
    reset = 1'b0; #1;
    reads = 0;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) tick;
      reads += int'(mem_rd);
      if (c >= 2) begin
        chk("bp_hold_iin", iin, 32'h1000);
        chk("bp_hold_valid", iin_valid, 1);
      end
    end
    chk("bp_reads", reads, 4);
    chk("bp_full_no_rd", mem_rd, 0);
    tick;
    chk("bp_c10_iin", iin, 32'h1000);
    chk("bp_c10_mem_rd", mem_rd, 0);
    iin_ready = 1'b1;
    for (int c = 11; c <= 17; c++) begin
      tick;
      chk("drain_valid", iin_valid, 1);
      chk("drain_iin", iin, 32'h1000 + c - 10);
      chk("drain_pc", iin_pc, c - 10);
      if (c == 11) begin
        chk("resume_mem_rd", mem_rd, 1);
        chk("resume_mem_addr", mem_addr, 4);
      end
    end

    // build 3 buffered words + 1 in flight, then jump to 0x40
    iin_ready = 1'b0;
    tick;
    chk("pj_iin_held", iin, 32'h1007);
    chk("pj_no_rd", mem_rd, 0);
    jump = 1'b1; jump_addr = 8'h40; iin_ready = 1'b1; #1;
    chk("jump_mem_rd", mem_rd, 0);
    tick;
    jump = 1'b0; #1;
    chk("j1_valid", iin_valid, 0);
    chk("j1_iin", iin, 0);
    chk("j1_pc", iin_pc, 0);
    chk("j1_mem_rd", mem_rd, 1);
    chk("j1_mem_addr", mem_addr, 32'h40);
    tick;
    chk("j2_valid", iin_valid, 0);
    chk("j2_mem_addr", mem_addr, 32'h41);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("j_valid", iin_valid, 1);
      chk("j_iin", iin, 32'h1040 + k);
      chk("j_pc", iin_pc, 32'h40 + k);
    end

    // jump near the top of the address space to exercise wrap
    jump = 1'b1; jump_addr = 8'hFE;
    tick;
    jump = 1'b0; #1;
    chk("w1_valid", iin_valid, 0);
    chk("w1_mem_addr", mem_addr, 32'hFE);
    tick;
    chk("w2_valid", iin_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("wrap_valid", iin_valid, 1);
      chk("wrap_pc", iin_pc, (32'hFE + k) & 32'hFF);
      chk("wrap_iin", iin, 32'h1000 + ((32'hFE + k) & 32'hFF));
    end

    // halt with one word in flight
    halt = 1'b1; #1;
    chk("halt_mem_rd", mem_rd, 0);
    tick;
    chk("halt_last_valid", iin_valid, 1);
    chk("halt_last_pc", iin_pc, 32'h02);
    chk("halt_last_iin", iin, 32'h1002);
    tick;
    chk("halt_empty_valid", iin_valid, 0);
    chk("halt_empty_iin", iin, 0);
    chk("halt_empty_rd", mem_rd, 0);
    tick;
    chk("halt_still_empty", iin_valid, 0);
    halt = 1'b0; #1;
    chk("unhalt_mem_rd", mem_rd, 1);
    chk("unhalt_mem_addr", mem_addr, 32'h03);
    tick;
    chk("unhalt_c1_valid", iin_valid, 0);
    tick;
    chk("unhalt_valid", iin_valid, 1);
    chk("unhalt_pc", iin_pc, 32'h03);
    chk("unhalt_iin", iin, 32'h1003);

    // asynchronous reset between edges
    #2;
    reset = 1'b1; #1;
    chk("areset_mem_rd", mem_rd, 0);
    chk("areset_valid", iin_valid, 0);
    chk("areset_iin", iin, 0);
    chk("areset_pc", iin_pc, 0);
    chk("areset_mem_addr", mem_addr, 0);
    tick; tick;
    reset = 1'b0; #1;
    chk("rerun_mem_rd", mem_rd, 1);
    chk("rerun_mem_addr", mem_addr, 0);
    tick; tick;
    chk("rerun_valid", iin_valid, 1);
    chk("rerun_iin", iin, 32'h1000);
    chk("rerun_pc", iin_pc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch unit that sits directly upstream of the processor and drives its 16-bit `iin` instruction input. It owns the program counter, issues reads to a synchronous instruction memory, and buffers returned words in a small prefetch FIFO. Each word is presented with a valid/ready handshake and its fetch address. A jump request redirects fetch and squashes all buffered and in-flight words.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction address width.
- `DEPTH`, default 4: prefetch FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: one clock; reset is asynchronous and active-high.
- `mem_addr`  out  ADDR_W: read address; equals `fetch_pc`.
- `mem_rd`  out  1: read strobe; memory returns `mem_data` in the next cycle.
- `mem_data`  in  16: instruction word for the read issued in the previous cycle.
- `iin`  out  16: head-of-FIFO instruction; connects to the processor's `iin`.
- `iin_pc`  out  ADDR_W: fetch address of `iin`.
- `iin_valid`  out  1: FIFO non-empty.
- `iin_ready`  in  1: processor accepts `iin` this cycle.
- `jump`  in  1: redirect fetch.
- `jump_addr`  in  ADDR_W: new fetch address.
- `halt`  in  1: stop issuing new reads.

## Operation
- State:
  - `fetch_pc` (ADDR_W).
  - FIFO of {pc, instr}, DEPTH entries, with read pointer, write pointer and `count` ($clog2(DEPTH+1) bits).
  - `inflight` (1 bit) plus `inflight_pc` (ADDR_W).
- Issue: `mem_rd = !reset && !jump && !halt && (count + inflight < DEPTH)`.
  - On issue: `inflight` <= 1, `inflight_pc` <= `fetch_pc`, `fetch_pc` <= `fetch_pc + 1`.
  - `fetch_pc` wraps modulo 2^ADDR_W (0xFF → 0x00 with ADDR_W = 8).
- Capture: if `inflight` = 1 and `jump` = 0, push {`inflight_pc`, `mem_data`}; `inflight` <= the issue condition of this cycle.
- Pop: when `iin_valid && iin_ready && !jump`.
- Push and pop in the same cycle: `count` is unchanged.
  - The issue rule guarantees no push when full.
  - The FIFO never overflows; popping when empty is impossible.
- Jump (priority over everything):
  - FIFO cleared: `count` <= 0, pointers <= 0.
  - `inflight` <= 0; the word returning next cycle is discarded.
  - `fetch_pc` <= `jump_addr`; `mem_rd` = 0 that cycle.
  - A handshake coinciding with `jump` is ignored.
- Halt: blocks new issues only.
  - An in-flight word is still captured.
  - FIFO still drains through the handshake.
- Reset (asynchronous, any time, including mid-fetch): `fetch_pc` = 0, `count` = 0, pointers = 0, `inflight` = 0.
  - Outputs: `iin` = 0, `iin_pc` = 0, `iin_valid` = 0, `mem_rd` = 0.
  - FIFO storage needs no reset; `iin`/`iin_pc` read 0 when empty.

## Timing
- Issue-to-valid latency is 2 cycles.
  - Cycle n: `mem_rd`.
  - Cycle n+1: `mem_data` captured at the edge.
  - Cycle n+2: `iin_valid`.
- After reset release, the first `mem_rd` is in cycle 0 at address 0; `iin_valid` rises in cycle 2.
- Sustained throughput is 1 instruction/cycle with `iin_ready` held high.
- Jump in cycle j:
  - First issue at `jump_addr` in cycle j+1.
  - `iin_valid` is 0 in cycles j+1 and j+2, returning in j+3.
- Backpressure: with `iin_ready` low, issuing stops once `count + inflight` = DEPTH.
  - It resumes in the same cycle that a pop brings the sum below DEPTH.
- `iin`, `iin_pc` and `iin_valid` are stable while `iin_valid && !iin_ready`, absent jump/reset.

## Structure
- Shared package holds:
  - `INSTR_W` = 16.
  - Default `ADDR_W` and `DEPTH`.
  - The FIFO entry typedef {pc, instr}.
- One sub-module, `fila_prefetch`: a parametric synchronous FIFO with push, pop, clear, count and head outputs, plus asynchronous reset.
- `unidade_busca` holds the PC, in-flight tracking and issue logic.

## Test plan
- Reset release, memory returns address+0x1000, `iin_ready` = 1 → `mem_rd` in cycles 0,1,2…; `iin` = 0x1000, 0x1001, 0x1002 from cycle 2, one per cycle, with matching `iin_pc`.
- `iin_ready` = 0 for 10 cycles → exactly 4 reads issued; FIFO full; `iin` = 0x1000 held; on release, 4 words pop in order, and reissue starts with no gap and no duplicate.
- `jump` = 1, `jump_addr` = 0x40, while FIFO holds 3 words and a read is in flight → `iin_valid` low 2 cycles, then `iin` = 0x1040 with `iin_pc` = 0x40; no stale word ever appears.
- `jump_addr` = 0xFE with `iin_ready` = 1 → `iin_pc` sequence 0xFE, 0xFF, 0x00, 0x01.
- `halt` asserted with 1 word in flight → that word is still delivered, then `iin_valid` falls; deassert `halt` → fetch resumes at the next sequential address.
- `reset` pulsed mid-stream, between clock edges → all outputs 0 immediately; after release, fetch restarts at address 0.
